// File: rtl/ms72xx_cfg_seq.sv
// ms72xx_cfg_seq: configuration sequencer for the MS72xx HDMI RX/TX pair.
// Walks a register table in an external synchronous ROM. Each entry becomes
// one write to the shared I2C byte engine, a timed delay, or the end of the
// table. NACKed writes are retried a bounded number of times.
// Optional build macro: MS72XX_CFG_READBACK_EN adds a read-back/verify of
// every write whose register high byte is not 0xFF.
//
// Handshake: iic_req is held high with iic_ch/dev/reg/wdata/rd stable until
// a cycle with iic_ack=1; the request drops on the following edge. iic_done
// is a one-cycle pulse, and iic_nack/iic_rdata are qualified by it. A done
// pulse outside a wait state is ignored.
module ms72xx_cfg_seq #(
    parameter int ADDR_W     = 8,
    parameter int CYC_PER_MS = 10000,
    parameter int PWRUP_CYC  = 20000,
    parameter int MAX_RETRY  = 3,
    parameter int AUTO_START = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic              iic_req,
    output logic              iic_ch,
    output logic [6:0]        iic_dev,
    output logic [15:0]       iic_reg,
    output logic [7:0]        iic_wdata,
    output logic              iic_rd,
    input  logic              iic_ack,
    input  logic              iic_done,
    input  logic              iic_nack,
    input  logic [7:0]        iic_rdata,
    output logic              busy,
    output logic              init_over,
    output logic              cfg_err,
    output logic [ADDR_W-1:0] err_idx,
    output logic [3:0]        dbg_state
);

    localparam int DLY_MAX = 255 * CYC_PER_MS;
    localparam int CNT_MAX = (DLY_MAX > PWRUP_CYC) ? DLY_MAX : PWRUP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0]  PWRUP_LOAD = CNT_W'(PWRUP_CYC - 1);
    localparam logic [RTRY_W-1:0] RETRY_LIM  = RTRY_W'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWRUP,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_DELAY,
        S_DONE,
        S_ERROR
`ifdef MS72XX_CFG_READBACK_EN
        ,
        S_RD_ISSUE,
        S_RD_WAIT
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RTRY_W-1:0]   retry_q, retry_d;
    logic                auto_q, auto_d;
    logic                ch_q, ch_d;
    logic [6:0]          dev_q, dev_d;
    logic [15:0]         reg_q, reg_d;
    logic [7:0]          wdata_q, wdata_d;
    logic                adv;
    logic                fail;
    logic [31:0]         dly_prod;

    // Delay length of the entry currently on the ROM bus.
    assign dly_prod = 32'(rom_data[7:0]) * 32'(CYC_PER_MS);

`ifndef MS72XX_CFG_READBACK_EN
    logic unused_rdata;
    assign unused_rdata = ^iic_rdata;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            retry_q <= '0;
            auto_q  <= (AUTO_START != 0);
            ch_q    <= 1'b0;
            dev_q   <= '0;
            reg_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            auto_q  <= auto_d;
            ch_q    <= ch_d;
            dev_q   <= dev_d;
            reg_q   <= reg_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state logic: per-state actions, then shared retry and advance rules.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        auto_d  = auto_q;
        ch_d    = ch_q;
        dev_d   = dev_q;
        reg_d   = reg_q;
        wdata_d = wdata_q;
        adv     = 1'b0;
        fail    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start || auto_q) begin
                    auto_d  = 1'b0;
                    state_d = S_PWRUP;
                    cnt_d   = PWRUP_LOAD;
                    retry_d = '0;
                    addr_d  = '0;
                end
            end
            S_PWRUP: begin
                if (cnt_q == '0) begin
                    addr_d  = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (rom_data[30:24] == 7'h7F) begin
                    state_d = S_DONE;
                end else if (rom_data[30:24] == 7'h00) begin
                    if (rom_data[7:0] == 8'h00) begin
                        adv = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(dly_prod - 32'd1);
                        state_d = S_DELAY;
                    end
                end else begin
                    ch_d    = rom_data[31];
                    dev_d   = rom_data[30:24];
                    reg_d   = rom_data[23:8];
                    wdata_d = rom_data[7:0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (iic_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (iic_done) begin
                    if (iic_nack) begin
                        fail = 1'b1;
                    end else begin
`ifdef MS72XX_CFG_READBACK_EN
                        if (reg_q[15:8] != 8'hFF) state_d = S_RD_ISSUE;
                        else                      adv = 1'b1;
`else
                        adv = 1'b1;
`endif
                    end
                end
            end
`ifdef MS72XX_CFG_READBACK_EN
            S_RD_ISSUE: begin
                if (iic_ack) state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (iic_done) begin
                    if (iic_nack || (iic_rdata != wdata_q)) fail = 1'b1;
                    else                                    adv  = 1'b1;
                end
            end
`endif
            S_DELAY: begin
                if (cnt_q == '0) adv = 1'b1;
                else             cnt_d = cnt_q - CNT_W'(1);
            end
            S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_PWRUP;
                    cnt_d   = PWRUP_LOAD;
                    retry_d = '0;
                    addr_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A failed write (or failed verify) reissues the write of the same entry.
        if (fail) begin
            if (retry_q < RETRY_LIM) begin
                retry_d = retry_q + RTRY_W'(1);
                state_d = S_ISSUE;
            end else begin
                state_d = S_ERROR;
            end
        end

        // Move to the next entry; the last ROM slot finishes the table without wrapping.
        if (adv) begin
            retry_d = '0;
            if (addr_q == '1) begin
                state_d = S_DONE;
            end else begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_FETCH;
            end
        end
    end

    assign rom_addr  = addr_q;
    assign iic_ch    = ch_q;
    assign iic_dev   = dev_q;
    assign iic_reg   = reg_q;
    assign iic_wdata = wdata_q;
`ifdef MS72XX_CFG_READBACK_EN
    assign iic_req   = (state_q == S_ISSUE) || (state_q == S_RD_ISSUE);
    assign iic_rd    = (state_q == S_RD_ISSUE) || (state_q == S_RD_WAIT);
`else
    assign iic_req   = (state_q == S_ISSUE);
    assign iic_rd    = 1'b0;
`endif
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
    assign init_over = (state_q == S_DONE);
    assign cfg_err   = (state_q == S_ERROR);
    assign err_idx   = (state_q == S_ERROR) ? addr_q : '0;
    assign dbg_state = state_q;

endmodule
